// File: rtl/ntt_bfu_pipe_pkg.sv
// bfu_pkg: shared types and mod-Q helpers for the NTT butterfly pipeline.
//   mode_t    - per-beat operation (CT, GS, GS-halve, pass-through)
//   DEFAULT_Q - Ncc-Sign prime modulus
//   calcMu    - Barrett constant floor(2^(2D)/Q)
//   modAdd / modSub / modHalve - single-correction mod-Q helpers
package bfu_pkg;

    typedef enum logic [1:0] {
        MODE_CT   = 2'b00,
        MODE_GS   = 2'b01,
        MODE_GSH  = 2'b10,
        MODE_PASS = 2'b11
    } mode_t;

    localparam int unsigned DEFAULT_Q = 134250497;

    // Helpers work on a wide word so one definition serves every D; callers
    // pass operands < Q < 2^D, so only the low D+1 bits ever carry value.
    localparam int unsigned WORD_W = 64;
    typedef logic [WORD_W-1:0] word_t;

    function automatic logic [127:0] calcMu(input logic [63:0] q, input int unsigned d);
        logic [127:0] num;
        num = 128'd1 << (2 * d);
        return num / {64'd0, q};
    endfunction

    function automatic word_t modAdd(input word_t a, input word_t b, input word_t q);
        word_t s;
        s = a + b;
        return (s >= q) ? s - q : s;
    endfunction

    function automatic word_t modSub(input word_t a, input word_t b, input word_t q);
        return (a >= b) ? a - b : a + q - b;
    endfunction

    // x/2 mod Q for odd Q: an odd x becomes even after adding Q.
    function automatic word_t modHalve(input word_t x, input word_t q);
        return x[0] ? (x + q) >> 1 : x >> 1;
    endfunction

endpackage

// File: rtl/ntt_bfu_pipe_if.sv
// ntt_bfu_pipe_if: beat bus between the NTT FSM / coefficient RAM and the
// butterfly pipeline.
//   iVALID, iSTALL, iMODE, iTAG, iA, iB, iW : beat into the pipeline
//   oVALID, oTAG, oA, oB                    : beat out of the pipeline
// Lane k of every data bus occupies bits [k*D +: D].
//   slave  - the pipeline side
//   master - the driver / write-back side
interface ntt_bfu_pipe_if
    import bfu_pkg::*;
#(
    parameter int unsigned D     = 28,
    parameter int unsigned LANES = 1,
    parameter int unsigned TAG_W = 8
) ();

    logic                 iVALID;
    logic                 iSTALL;
    mode_t                iMODE;
    logic [TAG_W-1:0]     iTAG;
    logic [LANES*D-1:0]   iA;
    logic [LANES*D-1:0]   iB;
    logic [LANES*D-1:0]   iW;
    logic                 oVALID;
    logic [TAG_W-1:0]     oTAG;
    logic [LANES*D-1:0]   oA;
    logic [LANES*D-1:0]   oB;

    modport slave (
        input  iVALID, iSTALL, iMODE, iTAG, iA, iB, iW,
        output oVALID, oTAG, oA, oB
    );

    modport master (
        output iVALID, iSTALL, iMODE, iTAG, iA, iB, iW,
        input  oVALID, oTAG, oA, oB
    );

endinterface

// File: rtl/ntt_bfu_pipe_mod_mul_barrett.sv
// mod_mul_barrett: 3-stage pipelined modular multiplier, oR = iX*iY mod Q.
//   iSYS_CLK - clock
//   iSYS_RST - asynchronous active-low reset
//   iEN      - advance enable; all stages hold while low
//   iX, iY   - operands, each < Q
//   oR       - product mod Q, valid 3 enabled edges after the operands
// Stage 1 forms the 2D-bit product, stage 2 the Barrett quotient estimate,
// stage 3 the remainder with two conditional subtractions.
module mod_mul_barrett
    import bfu_pkg::*;
#(
    parameter int unsigned D       = 28,
    parameter int unsigned PARAM_Q = DEFAULT_Q
) (
    input  logic         iSYS_CLK,
    input  logic         iSYS_RST,
    input  logic         iEN,
    input  logic [D-1:0] iX,
    input  logic [D-1:0] iY,
    output logic [D-1:0] oR
);

    localparam int unsigned PW = 2 * D;
    localparam int unsigned EW = 4 * D + 1;
    localparam logic [PW:0]  MU = (PW + 1)'(calcMu(64'(PARAM_Q), D));
    localparam logic [D+1:0] QX = (D + 2)'(PARAM_Q);

    logic [PW-1:0] prod;
    logic [D+1:0]  prodLo;
    logic [D-1:0]  quo;
    logic [D+1:0]  rRaw;
    logic [D+1:0]  r1;
    logic [D-1:0]  rOut;

    // Full-width estimate (x*MU) >> 2D undershoots x/Q by at most one, so the
    // remainder lies in [0, 2Q) and fits D+2 bits; only those bits of x are
    // needed to form it.
    always_comb begin
        rRaw = prodLo - (D + 2)'(quo) * QX;
        r1   = (rRaw >= QX) ? rRaw - QX : rRaw;
        rOut = D'((r1 >= QX) ? r1 - QX : r1);
    end

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            prod   <= '0;
            prodLo <= '0;
            quo    <= '0;
            oR     <= '0;
        end else if (iEN) begin
            prod   <= PW'(iX) * PW'(iY);
            quo    <= D'((EW'(prod) * EW'(MU)) >> PW);
            prodLo <= (D + 2)'(prod);
            oR     <= rOut;
        end
    end

endmodule

// File: rtl/ntt_bfu_pipe.sv
// ntt_bfu_pipe: 5-stage dual-mode NTT butterfly array.
//   iSYS_CLK - clock
//   iSYS_RST - asynchronous active-low reset, clears every stage
//   bus      - ntt_bfu_pipe_if.slave beat bus (valid/stall/mode/tag/A/B/W in,
//              valid/tag/A/B out)
// S1 registers the beat and does the GS pre-add/sub, S2-S4 are the per-lane
// Barrett multipliers, S5 does the CT add/sub or halving into the outputs.
// Mode, tag and valid ride a delay line alongside the data.
module ntt_bfu_pipe
    import bfu_pkg::*;
#(
    parameter int unsigned PARAM_Q = DEFAULT_Q,
    parameter int unsigned D       = 28,
    parameter int unsigned LANES   = 1,
    parameter int unsigned TAG_W   = 8
) (
    input  logic            iSYS_CLK,
    input  logic            iSYS_RST,
    ntt_bfu_pipe_if.slave   bus
);

    localparam word_t QW = word_t'(PARAM_Q);

    logic en;
    assign en = !bus.iSTALL;

    logic [LANES-1:0][D-1:0] s1AN, s1BN, s1WN;
    logic [LANES-1:0][D-1:0] s1B, s1W;
    logic [LANES-1:0][D-1:0] mulR;
    logic [LANES-1:0][D-1:0] oAN, oBN;

    // Stage-indexed delay line, index 1 = S1 .. 4 = S4.
    logic [4:1]                        vP;
    logic [4:1][1:0]                   mP;
    logic [4:1][TAG_W-1:0]             tP;
    logic [4:1][LANES-1:0][D-1:0]      aP;

    // Every mode is mapped onto "A path + multiplier path": pass uses W=1 so
    // B rides the multiplier with the same latency. Invalid beats load zeros
    // so their don't-care results stay below Q.
    always_comb begin
        s1AN = '0;
        s1BN = '0;
        s1WN = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (bus.iVALID) begin
                case (bus.iMODE)
                    MODE_GS, MODE_GSH: begin
                        s1AN[k] = D'(modAdd(word_t'(bus.iA[k*D +: D]), word_t'(bus.iB[k*D +: D]), QW));
                        s1BN[k] = D'(modSub(word_t'(bus.iA[k*D +: D]), word_t'(bus.iB[k*D +: D]), QW));
                        s1WN[k] = bus.iW[k*D +: D];
                    end
                    MODE_PASS: begin
                        s1AN[k] = bus.iA[k*D +: D];
                        s1BN[k] = bus.iB[k*D +: D];
                        s1WN[k] = D'(1);
                    end
                    default: begin
                        s1AN[k] = bus.iA[k*D +: D];
                        s1BN[k] = bus.iB[k*D +: D];
                        s1WN[k] = bus.iW[k*D +: D];
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : gLane
        mod_mul_barrett #(
            .D       (D),
            .PARAM_Q (PARAM_Q)
        ) uMul (
            .iSYS_CLK (iSYS_CLK),
            .iSYS_RST (iSYS_RST),
            .iEN      (en),
            .iX       (s1B[g]),
            .iY       (s1W[g]),
            .oR       (mulR[g])
        );
    end

    always_comb begin
        oAN = '0;
        oBN = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            case (mode_t'(mP[4]))
                MODE_CT: begin
                    oAN[k] = D'(modAdd(word_t'(aP[4][k]), word_t'(mulR[k]), QW));
                    oBN[k] = D'(modSub(word_t'(aP[4][k]), word_t'(mulR[k]), QW));
                end
                MODE_GSH: begin
                    oAN[k] = D'(modHalve(word_t'(aP[4][k]), QW));
                    oBN[k] = D'(modHalve(word_t'(mulR[k]), QW));
                end
                default: begin
                    oAN[k] = aP[4][k];
                    oBN[k] = mulR[k];
                end
            endcase
        end
    end

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            vP         <= '0;
            mP         <= '0;
            tP         <= '0;
            aP         <= '0;
            s1B        <= '0;
            s1W        <= '0;
            bus.oVALID <= 1'b0;
            bus.oTAG   <= '0;
            bus.oA     <= '0;
            bus.oB     <= '0;
        end else if (en) begin
            vP         <= {vP[3:1], bus.iVALID};
            mP         <= {mP[3:1], bus.iMODE};
            tP         <= {tP[3:1], bus.iTAG};
            aP         <= {aP[3:1], s1AN};
            s1B        <= s1BN;
            s1W        <= s1WN;
            bus.oVALID <= vP[4];
            bus.oTAG   <= tP[4];
            bus.oA     <= oAN;
            bus.oB     <= oBN;
        end
    end

endmodule

// File: tb/tb_ntt_bfu_pipe.sv
// tb_ntt_bfu_pipe: directed bench for ntt_bfu_pipe (LANES=4, default Q).
// A reference model computes each beat's results with plain modular
// arithmetic when the beat is sampled and ages it through five slots; a
// compare process checks the DUT against the oldest slot on every negedge.
// Literal checks pin both the model and the DUT on the hand-worked vectors.
module tb_ntt_bfu_pipe;
    import bfu_pkg::*;

    localparam int unsigned D     = 28;
    localparam int unsigned LANES = 4;
    localparam int unsigned TAG_W = 8;
    localparam longint unsigned Q = 134250497;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    ntt_bfu_pipe_if #(.D(D), .LANES(LANES), .TAG_W(TAG_W)) bus ();

    ntt_bfu_pipe #(
        .PARAM_Q (134250497),
        .D       (D),
        .LANES   (LANES),
        .TAG_W   (TAG_W)
    ) dut (
        .iSYS_CLK (clk),
        .iSYS_RST (rstN),
        .bus      (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit checkOn     = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit               v;
        logic [TAG_W-1:0] tag;
        longint unsigned  a [LANES];
        longint unsigned  b [LANES];
    } beat_t;

    beat_t pipe [5];

    function automatic longint unsigned half(input longint unsigned x);
        return (x * ((Q + 1) / 2)) % Q;   // multiply by the inverse of 2
    endfunction

    function automatic void refLane(input mode_t m, input longint unsigned a, input longint unsigned b,
                                    input longint unsigned w, output longint unsigned ra,
                                    output longint unsigned rb);
        longint unsigned t;
        case (m)
            MODE_CT: begin
                t  = (b * w) % Q;
                ra = (a + t) % Q;
                rb = (a + Q - t) % Q;
            end
            MODE_GS: begin
                ra = (a + b) % Q;
                rb = (((a + Q - b) % Q) * w) % Q;
            end
            MODE_GSH: begin
                ra = half((a + b) % Q);
                rb = half((((a + Q - b) % Q) * w) % Q);
            end
            default: begin
                ra = a;
                rb = b;
            end
        endcase
    endfunction

    // A sampled beat is on the outputs after the fifth enabled edge,
    // counting its sampling edge as the first.
    always @(posedge clk or negedge rstN) begin
        beat_t nb;
        longint unsigned ra, rb;
        if (!rstN) begin
            for (int i = 0; i < 5; i++) pipe[i].v = 1'b0;
        end else if (!bus.iSTALL) begin
            nb.v   = bus.iVALID;
            nb.tag = bus.iTAG;
            for (int k = 0; k < LANES; k++) begin
                refLane(bus.iMODE, longint'(bus.iA[k*D +: D]), longint'(bus.iB[k*D +: D]),
                        longint'(bus.iW[k*D +: D]), ra, rb);
                nb.a[k] = ra;
                nb.b[k] = rb;
            end
            for (int i = 4; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = nb;
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            chk("model_oVALID", longint'(bus.oVALID), longint'(pipe[4].v));
            for (int k = 0; k < LANES; k++) begin
                if (pipe[4].v) begin
                    chk("model_oA", longint'(bus.oA[k*D +: D]), pipe[4].a[k]);
                    chk("model_oB", longint'(bus.oB[k*D +: D]), pipe[4].b[k]);
                end else begin
                    chk("idle_oA_ltQ", longint'(bus.oA[k*D +: D] < D'(Q)), 1);
                    chk("idle_oB_ltQ", longint'(bus.oB[k*D +: D] < D'(Q)), 1);
                end
            end
            if (pipe[4].v) chk("model_oTAG", longint'(bus.oTAG), longint'(pipe[4].tag));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setLane(input int k, input longint unsigned a, input longint unsigned b,
                           input longint unsigned w);
        bus.iA[k*D +: D] = a[D-1:0];
        bus.iB[k*D +: D] = b[D-1:0];
        bus.iW[k*D +: D] = w[D-1:0];
    endtask

    task automatic setBeat(input bit v, input mode_t m, input logic [TAG_W-1:0] tag);
        bus.iVALID = v;
        bus.iMODE  = m;
        bus.iTAG   = tag;
    endtask

    task automatic chkOut(input string name, input int k, input longint unsigned ea,
                          input longint unsigned eb);
        chk({name, "_oA"}, longint'(bus.oA[k*D +: D]), ea);
        chk({name, "_oB"}, longint'(bus.oB[k*D +: D]), eb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned ra, rb;
        int validSeen;

        bus.iSTALL = 1'b0;
        setBeat(1'b0, MODE_CT, '0);
        bus.iA = '0;
        bus.iB = '0;
        bus.iW = '0;

        // pin the model on hand-worked values
        refLane(MODE_CT, 5, 3, 2, ra, rb);
        chk("ref_ct_a", ra, 11);  chk("ref_ct_b", rb, 134250496);
        refLane(MODE_GSH, 4, 3, 1, ra, rb);
        chk("ref_gsh_a", ra, 67125252);  chk("ref_gsh_b", rb, 67125249);

        // reset state
        #3;
        chk("rst_oVALID", longint'(bus.oVALID), 0);
        chk("rst_oTAG", longint'(bus.oTAG), 0);
        chk("rst_oA", longint'(bus.oA), 0);
        chk("rst_oB", longint'(bus.oB), 0);
        #20 rstN = 1'b1;
        checkOn = 1'b1;
        tick();

        // ---- directed vectors, one per mode ----
        setLane(0, 5, 3, 2); setLane(1, Q-1, Q-1, Q-1); setLane(2, 0, 0, 0); setLane(3, 1, 1, 1);
        setBeat(1'b1, MODE_CT, 8'h11);  tick();
        setLane(0, 5, 3, 2);
        setBeat(1'b1, MODE_GS, 8'h22);  tick();
        setLane(0, 5, 3, 2); setLane(1, 4, 3, 1);
        setBeat(1'b1, MODE_GSH, 8'h33); tick();
        setLane(0, 7, 9, 5);
        setBeat(1'b1, MODE_PASS, 8'h44); tick();
        setBeat(1'b0, MODE_CT, 8'h00);
        tick();
        chk("ct_valid", longint'(bus.oVALID), 1);
        chk("ct_tag", longint'(bus.oTAG), 'h11);
        chkOut("ct", 0, 11, 134250496);
        chkOut("ct_bound", 1, 0, 134250495);
        chkOut("ct_zero", 2, 0, 0);
        chkOut("ct_one", 3, 2, 0);
        tick();
        chk("gs_tag", longint'(bus.oTAG), 'h22);
        chkOut("gs", 0, 8, 4);
        tick();
        chk("gsh_tag", longint'(bus.oTAG), 'h33);
        chkOut("gsh", 0, 4, 2);
        chkOut("gsh_odd", 1, 67125252, 67125249);
        tick();
        chk("pass_tag", longint'(bus.oTAG), 'h44);
        chkOut("pass", 0, 7, 9);
        tick();
        chk("drain_valid", longint'(bus.oVALID), 0);

        // ---- 20 back-to-back random beats with a 3-cycle stall ----
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < LANES; k++)
                setLane(k, $urandom_range(32'(Q - 1)), $urandom_range(32'(Q - 1)),
                        $urandom_range(32'(Q - 1)));
            setBeat(1'b1, mode_t'(2'(n % 4)), TAG_W'(n));
            if (n == 10) begin
                bus.iSTALL = 1'b1;
                validSeen = int'(bus.oVALID);
                repeat (3) begin
                    tick();
                    chk("stall_hold_valid", longint'(bus.oVALID), longint'(validSeen));
                end
                bus.iSTALL = 1'b0;
            end
            tick();
        end
        setBeat(1'b0, MODE_CT, '0);
        repeat (6) tick();

        // ---- reset with three beats in flight ----
        setLane(0, 5, 3, 2);
        for (int n = 0; n < 4; n++) begin
            setBeat(1'b1, MODE_CT, TAG_W'(8'hA1 + n));
            tick();
        end
        setBeat(1'b0, MODE_CT, '0);
        tick();
        chk("pre_rst_valid", longint'(bus.oVALID), 1);
        chk("pre_rst_tag", longint'(bus.oTAG), 'hA1);
        #2 rstN = 1'b0;
        #1;
        chk("midrst_oVALID", longint'(bus.oVALID), 0);
        chk("midrst_oTAG", longint'(bus.oTAG), 0);
        chk("midrst_oA", longint'(bus.oA), 0);
        chk("midrst_oB", longint'(bus.oB), 0);
        tick();
        #3 rstN = 1'b1;
        tick();
        validSeen = 0;
        repeat (6) begin
            tick();
            if (bus.oVALID) validSeen++;
        end
        chk("flushed_beats", longint'(validSeen), 0);

        setLane(0, 4, 3, 1);
        setBeat(1'b1, MODE_CT, 8'h5A);
        tick();
        setBeat(1'b0, MODE_CT, '0);
        repeat (3) tick();
        chk("post_rst_early", longint'(bus.oVALID), 0);
        tick();
        chk("post_rst_valid", longint'(bus.oVALID), 1);
        chk("post_rst_tag", longint'(bus.oTAG), 'h5A);
        chkOut("post_rst", 0, 7, 1);
        repeat (3) tick();

        checkOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
